// File: rtl/avr_gpio_port_gen_if.sv
// IO-space bus between the AVR core and an IO register block.
// The core drives address, strobes and write data; the block returns read data.
interface avr_gpio_port_gen_if;
  logic [5:0] IO_Addr;
  logic       iore;
  logic       iowe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;

  modport master (output IO_Addr, iore, iowe, dbus_in, input dbus_out, out_en);
  modport slave  (input IO_Addr, iore, iowe, dbus_in, output dbus_out, out_en);
endinterface

// File: rtl/avr_gpio_port_gen.sv
// Parametrised AVR GPIO port: PORTx/DDRx/PCMSKx, PINx toggle, 2-stage input sync,
// pin-change flag and per-bit alternate-function overrides of the pad controls.
module avr_gpio_port_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter logic [5:0]  PIN_ADDR   = 6'h09,
  parameter logic [5:0]  DDR_ADDR   = 6'h0A,
  parameter logic [5:0]  PORT_ADDR  = 6'h0B,
  parameter logic [5:0]  PCMSK_ADDR = 6'h0C
) (
  input  logic             cp2,
  input  logic             ireset,
  avr_gpio_port_gen_if.slave io,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             PUD,
  input  logic             SLEEP,
  input  logic [WIDTH-1:0] puoe,
  input  logic [WIDTH-1:0] puov,
  input  logic [WIDTH-1:0] ddoe,
  input  logic [WIDTH-1:0] ddov,
  input  logic [WIDTH-1:0] pvoe,
  input  logic [WIDTH-1:0] pvov,
  input  logic [WIDTH-1:0] dieoe,
  input  logic [WIDTH-1:0] dieov,
  input  logic             pcie,
  input  logic             pcif_clr,
  output logic [WIDTH-1:0] pin_sync_o,
  output logic [WIDTH-1:0] pu_n,
  output logic [WIDTH-1:0] dd_o,
  output logic [WIDTH-1:0] pv_o,
  output logic [WIDTH-1:0] din_dis,
  output logic             pcif,
  output logic             pc_irq
);

  logic [WIDTH-1:0] port_q, port_d;
  logic [WIDTH-1:0] ddr_q, ddr_d;
  logic [WIDTH-1:0] pcmsk_q, pcmsk_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;
  logic             pcif_q, pcif_d;

  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] pu_int;
  logic             pc_evt;

  // Only the implemented bits of the bus take part in any write, toggle included.
  assign wr_data = io.dbus_in[WIDTH-1:0];

  always_comb begin
    pu_int  = (puoe & puov) | (~puoe & port_q & ~ddr_q & {WIDTH{~PUD}});
    pu_n    = ~pu_int;
    dd_o    = (ddoe & ddov) | (~ddoe & ddr_q);
    pv_o    = (pvoe & pvov) | (~pvoe & port_q);
    din_dis = (dieoe & ~dieov) | (~dieoe & {WIDTH{SLEEP}});
  end

  always_comb begin
    port_d  = port_q;
    ddr_d   = ddr_q;
    pcmsk_d = pcmsk_q;
    if (io.iowe) begin
      if (io.IO_Addr == DDR_ADDR)   ddr_d   = wr_data;
      if (io.IO_Addr == PORT_ADDR)  port_d  = wr_data;
      if (io.IO_Addr == PCMSK_ADDR) pcmsk_d = wr_data;
      if (io.IO_Addr == PIN_ADDR)   port_d  = port_q ^ wr_data;
    end
  end

  always_comb begin
    s1_d   = pin_i & ~din_dis;
    s2_d   = s1_q;
    s3_d   = s2_q;
    pc_evt = |((s2_q ^ s3_q) & pcmsk_q);
    // A new change in the same cycle as a clear must not be lost.
    if (pc_evt)        pcif_d = 1'b1;
    else if (pcif_clr) pcif_d = 1'b0;
    else               pcif_d = pcif_q;
  end

  always_comb begin
    io.dbus_out = '0;
    io.out_en   = 1'b0;
    if (io.iore) begin
      if (io.IO_Addr == PIN_ADDR) begin
        io.dbus_out[WIDTH-1:0] = s2_q;
        io.out_en              = 1'b1;
      end else if (io.IO_Addr == DDR_ADDR) begin
        io.dbus_out[WIDTH-1:0] = ddr_q;
        io.out_en              = 1'b1;
      end else if (io.IO_Addr == PORT_ADDR) begin
        io.dbus_out[WIDTH-1:0] = port_q;
        io.out_en              = 1'b1;
      end else if (io.IO_Addr == PCMSK_ADDR) begin
        io.dbus_out[WIDTH-1:0] = pcmsk_q;
        io.out_en              = 1'b1;
      end
    end
  end

  assign pin_sync_o = s2_q;
  assign pcif       = pcif_q;
  assign pc_irq     = pcif_q & pcie;

  always_ff @(posedge cp2) begin
    if (ireset) begin
      port_q  <= '0;
      ddr_q   <= '0;
      pcmsk_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      pcif_q  <= 1'b0;
    end else begin
      port_q  <= port_d;
      ddr_q   <= ddr_d;
      pcmsk_q <= pcmsk_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      pcif_q  <= pcif_d;
    end
  end

endmodule

// File: tb/tb_avr_gpio_port_gen.sv
// Bench for avr_gpio_port_gen: an 8-bit port checked every cycle against a sample-history
// model, plus a 4-bit port checked with directed expectations.
module tb_avr_gpio_port_gen;

  logic cp2 = 1'b0;
  logic ireset;
  logic [7:0] pin_i, puoe, puov, ddoe, ddov, pvoe, pvov, dieoe, dieov;
  logic PUD, SLEEP, pcie, pcif_clr;
  logic [7:0] pin_sync_o, pu_n, dd_o, pv_o, din_dis;
  logic pcif, pc_irq;
  logic [3:0] ddoe4, ddov4;
  logic [3:0] d4_pin_sync, d4_pu_n, d4_dd, d4_pv, d4_din_dis;
  logic d4_pcif, d4_pc_irq;

  int checks = 0;
  int errors = 0;

  avr_gpio_port_gen_if bus8 ();
  avr_gpio_port_gen_if bus4 ();

  avr_gpio_port_gen #(.WIDTH(8)) dut8 (
    .cp2(cp2), .ireset(ireset), .io(bus8.slave), .pin_i(pin_i), .PUD(PUD), .SLEEP(SLEEP),
    .puoe(puoe), .puov(puov), .ddoe(ddoe), .ddov(ddov), .pvoe(pvoe), .pvov(pvov),
    .dieoe(dieoe), .dieov(dieov), .pcie(pcie), .pcif_clr(pcif_clr),
    .pin_sync_o(pin_sync_o), .pu_n(pu_n), .dd_o(dd_o), .pv_o(pv_o), .din_dis(din_dis),
    .pcif(pcif), .pc_irq(pc_irq)
  );

  avr_gpio_port_gen #(.WIDTH(4)) dut4 (
    .cp2(cp2), .ireset(ireset), .io(bus4.slave), .pin_i(4'h0), .PUD(PUD), .SLEEP(SLEEP),
    .puoe(4'h0), .puov(4'h0), .ddoe(ddoe4), .ddov(ddov4), .pvoe(4'h0), .pvov(4'h0),
    .dieoe(4'h0), .dieov(4'h0), .pcie(pcie), .pcif_clr(pcif_clr),
    .pin_sync_o(d4_pin_sync), .pu_n(d4_pu_n), .dd_o(d4_dd), .pv_o(d4_pv),
    .din_dis(d4_din_dis), .pcif(d4_pcif), .pc_irq(d4_pc_irq)
  );

  always #5 cp2 = ~cp2;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: registers plus the history of gated pad samples, one per edge since reset.
  // PINx shows the sample taken two edges back; a flag rises when it differs from the one before.
  logic [7:0] m_port, m_ddr, m_pcmsk;
  logic       m_pcif;
  logic       m_valid = 1'b0;
  logic [7:0] smp[$];

  function automatic logic [7:0] exp_din_dis();
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = dieoe[i] ? ~dieov[i] : SLEEP;
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge cp2);
      if (ireset) begin
        m_port = '0; m_ddr = '0; m_pcmsk = '0; m_pcif = 1'b0;
        smp = '{8'h00, 8'h00, 8'h00};
        m_valid = 1'b1;
      end else if (m_valid) begin
        if ((smp[1] ^ smp[0]) & m_pcmsk) m_pcif = 1'b1;
        else if (pcif_clr)               m_pcif = 1'b0;
        if (bus8.iowe) begin
          case (bus8.IO_Addr)
            6'h09: m_port = m_port ^ bus8.dbus_in;
            6'h0A: m_ddr = bus8.dbus_in;
            6'h0B: m_port = bus8.dbus_in;
            6'h0C: m_pcmsk = bus8.dbus_in;
            default: ;
          endcase
        end
        smp.push_back(pin_i & ~exp_din_dis());
        void'(smp.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge cp2);
      if (m_valid) begin
        logic [7:0] e_rd, e_pu, e_dd, e_pv;
        logic e_en;
        e_rd = 8'h00; e_en = 1'b0;
        if (bus8.iore) begin
          e_en = 1'b1;
          case (bus8.IO_Addr)
            6'h09: e_rd = smp[1];
            6'h0A: e_rd = m_ddr;
            6'h0B: e_rd = m_port;
            6'h0C: e_rd = m_pcmsk;
            default: e_en = 1'b0;
          endcase
        end
        for (int i = 0; i < 8; i++) begin
          e_pu[i] = puoe[i] ? ~puov[i] : ~(m_port[i] && !m_ddr[i] && !PUD);
          e_dd[i] = ddoe[i] ? ddov[i] : m_ddr[i];
          e_pv[i] = pvoe[i] ? pvov[i] : m_port[i];
        end
        chk("dbus_out", bus8.dbus_out, e_rd);
        chk("out_en", {7'd0, bus8.out_en}, {7'd0, e_en});
        chk("pin_sync_o", pin_sync_o, smp[1]);
        chk("pu_n", pu_n, e_pu);
        chk("dd_o", dd_o, e_dd);
        chk("pv_o", pv_o, e_pv);
        chk("din_dis", din_dis, exp_din_dis());
        chk("pcif", {7'd0, pcif}, {7'd0, m_pcif});
        chk("pc_irq", {7'd0, pc_irq}, {7'd0, m_pcif & pcie});
      end
    end
  end

  task automatic wr(input bit narrow, input logic [5:0] a, input logic [7:0] d);
    @(posedge cp2); #1;
    if (narrow) begin bus4.iowe = 1'b1; bus4.IO_Addr = a; bus4.dbus_in = d; end
    else        begin bus8.iowe = 1'b1; bus8.IO_Addr = a; bus8.dbus_in = d; end
    @(posedge cp2); #1;
    bus4.iowe = 1'b0; bus8.iowe = 1'b0;
  endtask

  task automatic rd(input bit narrow, input logic [5:0] a, input logic [7:0] e, input string nm);
    @(posedge cp2); #1;
    if (narrow) begin bus4.iore = 1'b1; bus4.IO_Addr = a; end
    else        begin bus8.iore = 1'b1; bus8.IO_Addr = a; end
    @(negedge cp2);
    chk(nm, narrow ? bus4.dbus_out : bus8.dbus_out, e);
    chk({nm, "_en"}, {7'd0, narrow ? bus4.out_en : bus8.out_en}, 8'h01);
    @(posedge cp2); #1;
    bus4.iore = 1'b0; bus8.iore = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge cp2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ireset = 1'b1;
    pin_i = '0; puoe = '0; puov = '0; ddoe = '0; ddov = '0; pvoe = '0; pvov = '0;
    dieoe = '0; dieov = '0; PUD = 1'b0; SLEEP = 1'b0; pcie = 1'b0; pcif_clr = 1'b0;
    ddoe4 = '0; ddov4 = '0;
    bus8.iore = 1'b0; bus8.iowe = 1'b0; bus8.IO_Addr = '0; bus8.dbus_in = '0;
    bus4.iore = 1'b0; bus4.iowe = 1'b0; bus4.IO_Addr = '0; bus4.dbus_in = '0;
    edges(2); #1 ireset = 1'b0;

    // Reset state
    rd(0, 6'h0A, 8'h00, "rst_ddr");
    rd(0, 6'h0B, 8'h00, "rst_port");
    rd(0, 6'h09, 8'h00, "rst_pin");
    rd(0, 6'h0C, 8'h00, "rst_pcmsk");
    @(negedge cp2);
    chk("rst_out_en_idle", {7'd0, bus8.out_en}, 8'h00);
    chk("rst_pu_n", pu_n, 8'hFF);
    chk("rst_dd_o", dd_o, 8'h00);

    // PORT write then PIN toggle
    wr(0, 6'h0B, 8'hA5);
    wr(0, 6'h09, 8'h0F);
    rd(0, 6'h0B, 8'hAA, "toggle_port");
    chk("toggle_pv_o", pv_o, 8'hAA);
    chk("toggle_pu_n", pu_n, 8'h55);

    // Pin change on a masked bit
    wr(0, 6'h0C, 8'h04);
    @(posedge cp2); #1 pcie = 1'b1; pin_i = 8'h04;
    edges(2);
    @(negedge cp2);
    chk("pc_sync_k1", pin_sync_o, 8'h04);
    chk("pc_flag_k1", {7'd0, pcif}, 8'h00);
    edges(1);
    @(negedge cp2);
    chk("pc_flag_k2", {7'd0, pcif}, 8'h01);
    chk("pc_irq_k2", {7'd0, pc_irq}, 8'h01);
    @(posedge cp2); #1 pcif_clr = 1'b1;
    @(posedge cp2); #1 pcif_clr = 1'b0;
    @(negedge cp2);
    chk("pc_cleared", {7'd0, pcif}, 8'h00);
    @(posedge cp2); #1 pin_i = 8'h0C;
    edges(4);
    @(negedge cp2);
    chk("pc_unmasked", {7'd0, pcif}, 8'h00);

    // Set wins over a simultaneous clear
    @(posedge cp2); #1 pin_i = 8'h08;
    edges(3);
    @(negedge cp2);
    chk("pc_fall_flag", {7'd0, pcif}, 8'h01);
    @(posedge cp2); #1 pin_i = 8'h0C;
    edges(1);
    @(posedge cp2); #1 pcif_clr = 1'b1;
    @(posedge cp2);
    @(negedge cp2);
    chk("pc_set_wins", {7'd0, pcif}, 8'h01);
    @(posedge cp2); #1 pcif_clr = 1'b0;
    @(negedge cp2);
    chk("pc_clr_alone", {7'd0, pcif}, 8'h00);
    pcie = 1'b0;

    // Sleep gating and digital-input-enable override
    @(posedge cp2); #1 SLEEP = 1'b1; pin_i = 8'hFF;
    edges(2);
    rd(0, 6'h09, 8'h00, "sleep_pin");
    @(posedge cp2); #1 dieoe = 8'h01; dieov = 8'h01;
    @(negedge cp2);
    chk("die_din_dis", din_dis, 8'hFE);
    edges(2);
    rd(0, 6'h09, 8'h01, "die_pin");
    @(posedge cp2); #1 SLEEP = 1'b0; dieoe = '0; dieov = '0; pin_i = 8'h5A;

    // Toggle under a port-value override, pull-up/direction overrides, PUD
    @(posedge cp2); #1 pvoe = 8'hFF; pvov = 8'h00;
    wr(0, 6'h09, 8'hFF);
    rd(0, 6'h0B, 8'h55, "pvoe_port");
    chk("pvoe_pv_o", pv_o, 8'h00);
    pvoe = 8'h00; puoe = 8'hF0; puov = 8'h30; ddoe = 8'h81; ddov = 8'h01;
    @(negedge cp2);
    chk("ovr_pv_o", pv_o, 8'h55);
    chk("ovr_pu_n", pu_n, 8'hCA);
    wr(0, 6'h0A, 8'h0F);
    @(posedge cp2); #1 PUD = 1'b1; puoe = '0;
    @(negedge cp2);
    chk("pud_pu_n", pu_n, 8'hFF);
    chk("ovr_dd_o", dd_o, 8'h0F);
    @(posedge cp2); #1 PUD = 1'b0; ddoe = '0; ddov = '0;

    // Narrow port
    wr(1, 6'h0B, 8'hFF);
    rd(1, 6'h0B, 8'h0F, "w4_port");
    wr(1, 6'h09, 8'hF0);
    rd(1, 6'h0B, 8'h0F, "w4_toggle_hi");
    wr(1, 6'h09, 8'h05);
    rd(1, 6'h0B, 8'h0A, "w4_toggle");
    @(posedge cp2); #1 ddoe4 = 4'b0010; ddov4 = 4'b0010;
    @(negedge cp2);
    chk("w4_dd_o", {4'd0, d4_dd}, 8'h02);

    // Reset during a write discards the write
    @(posedge cp2); #1;
    ireset = 1'b1;
    bus4.iowe = 1'b1; bus4.IO_Addr = 6'h0B; bus4.dbus_in = 8'h0C;
    bus8.iowe = 1'b1; bus8.IO_Addr = 6'h0B; bus8.dbus_in = 8'h3C;
    @(posedge cp2); #1;
    ireset = 1'b0; bus4.iowe = 1'b0; bus8.iowe = 1'b0;
    rd(1, 6'h0B, 8'h00, "w4_rst_port");
    rd(0, 6'h0B, 8'h00, "rst_wr_port");
    edges(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avr_gpio_port_gen.md
Name: avr_gpio_port_gen

Overview:
- Parametrised next-generation GPIO port for the ATmega328PB core; replaces per-port hand-written wrappers (B/C/D/E) with one block.
- Holds PORTx/DDRx/PCMSKx, 2-stage input synchroniser, PINx-write toggle, pin-change flag/IRQ.
- Applies per-bit alternate-function override vectors from peripherals (timers, USART, INT) to produce pad controls.
- Sits on the IO bus beside other IO-space registers; pad outputs go to the pad ring.

Parameters:
- WIDTH, 8, implemented pin count (1..8); bus bits [7:WIDTH] read 0, writes ignored.
- PIN_ADDR, 6'h09, IO address of PINx.
- DDR_ADDR, 6'h0A, IO address of DDRx.
- PORT_ADDR, 6'h0B, IO address of PORTx.
- PCMSK_ADDR, 6'h0C, IO address of pin-change mask register.

Ports:
- cp2  in  1  clock; all state on rising edge.
- ireset  in  1  synchronous, active-high reset.
- IO_Addr  in  6  IO register address.
- iore  in  1  IO read strobe.
- iowe  in  1  IO write strobe.
- dbus_in  in  8  write data.
- dbus_out  out  8  read data.
- out_en  out  1  high while this block drives dbus_out.
- pin_i  in  WIDTH  raw pad input.
- PUD  in  1  global pull-up disable.
- SLEEP  in  1  sleep; disables unoverridden input buffers.
- puoe/puov, ddoe/ddov, pvoe/pvov, dieoe/dieov  in  WIDTH each  override enable/value: pull-up, direction, port value, digital-input-enable.
- pcie  in  1  pin-change interrupt enable for this port.
- pcif_clr  in  1  clear pulse from PCIFR write-one or IRQ acknowledge.
- pin_sync_o  out  WIDTH  synchronised pin value for peripherals (INTx, ICP).
- pu_n  out  WIDTH  pull-up enable, active-low.
- dd_o  out  WIDTH  pad output enable.
- pv_o  out  WIDTH  pad output value.
- din_dis  out  WIDTH  input-buffer disable, active-high.
- pcif  out  1  pin-change flag.
- pc_irq  out  1  pcif & pcie.

Behaviour:
- Reset: PORTx, DDRx, PCMSK, both sync stages, change-history register, pcif all 0. dbus_out=0, out_en=0, pc_irq=0.
- Writes (iowe & address match), effective next edge:
  - DDR_ADDR: load DDRx.
  - PORT_ADDR: load PORTx.
  - PCMSK_ADDR: load PCMSK.
  - PIN_ADDR: PORTx <= PORTx ^ dbus_in[WIDTH-1:0]. PINx itself is not writable.
- Reads: combinational, zero wait. iore & match -> out_en=1, dbus_out = register zero-extended to 8 bits; otherwise dbus_out=0, out_en=0.
  - PIN_ADDR returns sync stage 2.
- Input path:
  - gated = pin_i & ~din_dis; masked bits feed 0 into the synchroniser.
  - s1 <= gated; s2 <= s1; pin_sync_o = s2.
  - A pin_i change before edge k is visible on PINx/pin_sync_o after edge k+1.
- Pin change detection:
  - s3 <= s2.
  - pc_evt = |((s2 ^ s3) & PCMSK).
  - pcif <= 1 on pc_evt, i.e. pcif is visible after edge k+2.
  - pcif_clr clears it. If pc_evt and pcif_clr occur in the same cycle, set wins.
  - pcif sets regardless of pcie; pc_irq = pcif & pcie, combinational.
- Pad control, per bit i, combinational:
  - pu_int = puoe ? puov : (PORTx & ~DDRx & ~PUD); pu_n = ~pu_int.
  - dd_o = ddoe ? ddov : DDRx.
  - pv_o = pvoe ? pvov : PORTx.
  - din_dis = dieoe ? ~dieov : SLEEP.
- Toggle via PIN write applies even when pvoe overrides. PORTx changes; pv_o does not until the override drops.
- Reset asserted mid-operation: all registers clear on that edge; a write in the same cycle is discarded.
- WIDTH<8: dbus_in[7:WIDTH] ignored on every write, including PIN toggle.

Test Plan:
- Reset, then read DDR/PORT/PIN/PCMSK -> all 8'h00, out_en=1 only during each read; pu_n=all 1, dd_o=0.
- Write PORT=8'hA5, then write PIN=8'h0F -> PORT reads 8'hAA; pv_o=8'hAA; DDR=0, PUD=0 -> pu_n=8'h55.
- PCMSK=8'h04, pcie=1, toggle pin_i[2] before edge k -> PIN[2]=1 after k+1; pcif=1 and pc_irq=1 after k+2; toggle pin_i[3] instead -> pcif stays 0.
- pcif=1, pcif_clr pulsed in the same cycle as a new masked change -> pcif remains 1; pcif_clr alone next cycle -> pcif=0.
- SLEEP=1, dieoe=0, pin_i=8'hFF -> PIN reads 8'h00 after 2 edges; set dieoe[0]=1, dieov[0]=1 -> PIN[0]=1 after 2 edges, din_dis[0]=0.
- WIDTH=4: write PORT=8'hFF -> reads 8'h0F; ddoe[1]=1, ddov[1]=1 with DDR=0 -> dd_o=4'b0010; reset asserted during a write -> PORT=0.
